ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//   Execute-stage iterative multiply/divide unit with HI/LO registers for the 5-stage MIPS core.
//   Consumes operands and the decoded mul/div op from the ID/EX pipeline register outputs.
//   Runs MULT/MULTU/DIV/DIVU in 33 cycles; MTHI/MTLO finish in one cycle.
//   Asserts busy so the hazard logic can stall the front end.
//   HI/LO are exposed for MFHI/MFLO forwarding.
// PARAMETERS
//   WIDTH    32   operand width; hi/lo each WIDTH bits
//   CNT_W    6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous active-low reset
//   start    in   1      issue op; sampled only in IDLE
//   op       in   3      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=reserved
//   rs_val   in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   rt_val   in   WIDTH  multiplier / divisor
//   flush    in   1      abort in-flight op (branch/exception squash)
//   busy     out  1      unit occupied; front end must hold
//   done     out  1      one-cycle pulse, valid in the same cycle as the new hi/lo
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// BEHAVIOUR
//   Reset:
//   - rst_n=0 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//   - Reset overrides flush and start, including mid-operation.
//   States:
//   - IDLE: start&&!flush with op 0-3 -> CALC, counter=0, operands latched.
//     - Signed ops latch magnitudes plus result-sign flags.
//     - MTHI/MTLO: write hi or lo with rs_val on the start edge, done=1 next cycle, stay IDLE, busy stays 0.
//     - Reserved op: ignored, no done.
//   - CALC: one iteration per edge.
//     - Multiply: shift-add, 64-bit product.
//     - Divide: restoring, 1 quotient bit per edge.
//     - Goes to FIXUP on the edge where counter==WIDTH-1 (32 CALC edges).
//   - FIXUP: apply sign correction, write hi/lo, done=1, -> IDLE.
//   Timing:
//   - Latency is 33 edges from the start edge to the hi/lo-write edge.
//   - busy=1 from the cycle after the start edge up to and including the FIXUP cycle; busy=0 in the done cycle.
//   - done is registered and high for exactly one cycle.
//   - start while busy is ignored; no queueing.
//   Arithmetic:
//   - Multiply: {hi,lo} = full 2*WIDTH product.
//   - Signed multiply negates the product iff exactly one operand is negative.
//   - Divide: lo=quotient, hi=remainder.
//   - Signed divide: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
//   - Divide by zero (signed or unsigned): lo=all ones, hi=rs_val. Still takes the full 33 cycles.
//   - DIV 0x80000000 / -1: lo=0x80000000, hi=0, no trap.
//   Flush:
//   - flush=1 in CALC/FIXUP: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
//   - flush and start in the same IDLE cycle: flush wins, op dropped. This includes MTHI/MTLO.
// TESTING
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> 33 edges later hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
//   2. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   3. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. Flush 10 edges after starting DIVU 100/7 -> busy=0 next cycle, no done, hi/lo keep prior values.
//   5. MTHI 0x1234 then MTLO 0x5678 -> each pulses done after one edge with busy=0. A start issued 5 cycles into a MULT is ignored, and only that MULT's result appears.
//   6. rst_n=0 during CALC -> next cycle hi=lo=0, busy=0, done=0. A new MULTU 2*3 then yields lo=6, hi=0.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ID/EX pipeline register and the iterative mul/div unit.
// The master drives the operation; the slave (the unit) returns busy/done and HI/LO.
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO: 32 shift-add or restoring-divide steps plus a
// sign-fixup cycle. MTHI/MTLO write directly from IDLE.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         rst_n,
    ex_muldiv_if.slave  bus
);
    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, rs_q, hi_q, lo_q;
    logic               is_div_q, neg_q, rneg_q, div0_q, done_q;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    // Signed ops iterate on magnitudes; the signs are reapplied in FIXUP.
    always_comb begin
        signed_op = (bus.op == OpMult) || (bus.op == OpDiv);
        a_neg     = signed_op && bus.rs_val[WIDTH-1];
        b_neg     = signed_op && bus.rt_val[WIDTH-1];
        a_mag     = a_neg ? -bus.rs_val : bus.rs_val;
        b_mag     = b_neg ? -bus.rt_val : bus.rt_val;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_sub   = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            acc_d = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            fix_hi = rs_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            rs_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                state_q  <= StCalc;
                                cnt_q    <= '0;
                                acc_q    <= {{WIDTH{1'b0}}, a_mag};
                                opb_q    <= b_mag;
                                rs_q     <= bus.rs_val;
                                is_div_q <= bus.op[1];
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                div0_q   <= (bus.rt_val == '0);
                            end
                            OpMthi: begin
                                hi_q   <= bus.rs_val;
                                done_q <= 1'b1;
                            end
                            OpMtlo: begin
                                lo_q   <= bus.rs_val;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= StFixup;
                    end
                end
                StFixup: begin
                    state_q <= StIdle;
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
